// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit.
//   md_op_e    : op codes presented on muldiv_unit.op
//   md_state_e : control FSM states (prefixed MD_ST_ so MD_DIV stays free for the op code)
//   op_is_div / op_is_signed : op-code field decoders
package muldiv_pkg;

    typedef enum logic [1:0] {
        MD_MULT  = 2'b00,
        MD_MULTU = 2'b01,
        MD_DIV   = 2'b10,
        MD_DIVU  = 2'b11
    } md_op_e;

    typedef enum logic [1:0] {
        MD_ST_IDLE = 2'b00,
        MD_ST_MUL  = 2'b01,
        MD_ST_DIV  = 2'b10,
        MD_ST_DONE = 2'b11
    } md_state_e;

    // Bit 1 of the op code selects divide
    function automatic logic op_is_div(input logic [1:0] op);
        return op[1];
    endfunction

    // Bit 0 clear means the signed flavour (MULT / DIV)
    function automatic logic op_is_signed(input logic [1:0] op);
        return ~op[0];
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the multiply/divide datapath (purely combinational).
//   is_div   : 1 = restoring-divide step, 0 = shift-add multiply step
//   acc_hi   : MUL: upper product half      DIV: partial remainder
//   acc_lo   : MUL: remaining multiplier    DIV: dividend bits / quotient being built
//   operand  : MUL: multiplicand            DIV: divisor
//   next_hi/next_lo : accumulator after this step
module muldiv_step
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             is_div,
    input  logic [WIDTH-1:0] acc_hi,
    input  logic [WIDTH-1:0] acc_lo,
    input  logic [WIDTH-1:0] operand,
    output logic [WIDTH-1:0] next_hi,
    output logic [WIDTH-1:0] next_lo
);

    logic [WIDTH:0] sum_s;
    logic [WIDTH:0] shifted_s;
    logic [WIDTH:0] diff_s;

    // Add-shift for multiply, subtract-compare for divide
    always_comb begin
        // Conditional add of the multiplicand keeps its carry in bit WIDTH
        sum_s     = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, operand} : {(WIDTH+1){1'b0}});
        // Partial remainder shifted left with the next dividend bit; WIDTH+1 bits wide
        shifted_s = {acc_hi, acc_lo[WIDTH-1]};
        // Remainder stays below the divisor, so bit WIDTH of the difference is a clean borrow flag
        diff_s    = shifted_s - {1'b0, operand};
        if (is_div) begin
            if (diff_s[WIDTH]) begin
                next_hi = shifted_s[WIDTH-1:0];
            end else begin
                next_hi = diff_s[WIDTH-1:0];
            end
            next_lo = {acc_lo[WIDTH-2:0], ~diff_s[WIDTH]};
        end else begin
            next_hi = sum_s[WIDTH:1];
            next_lo = {sum_s[0], acc_lo[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU engine with HI/LO result registers.
//   clk, rst            : clock and synchronous active-high reset
//   start, op, src1/2   : launch request (sampled in IDLE only), op code, operands
//   cancel              : abort a running op; HI/LO untouched
//   wr_hi, wr_lo, wr_data : MTHI/MTLO writes, honoured in IDLE only
//   busy, stall_req     : engine running / pipeline hold request
//   done                : one-cycle pulse, HI/LO already hold the result
//   hi, lo              : result registers
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] src1,
    input  logic [WIDTH-1:0] src2,
    input  logic             cancel,
    input  logic             wr_hi,
    input  logic             wr_lo,
    input  logic [WIDTH-1:0] wr_data,
    output logic             busy,
    output logic             stall_req,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int               CNT_W    = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    md_state_e          state_r, state_nxt_s;
    logic [CNT_W-1:0]   cnt_r;
    logic [WIDTH-1:0]   acc_hi_r, acc_lo_r, operand_r;
    logic [WIDTH-1:0]   hi_r, lo_r;
    logic               neg_res_r, neg_rem_r;
    logic               launch_s, div_zero_s, is_signed_s;
    logic [WIDTH-1:0]   mag1_s, mag2_s;
    logic [WIDTH-1:0]   step_hi_s, step_lo_s, res_hi_s, res_lo_s;
    logic [2*WIDTH-1:0] prod_s;

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .is_div  (state_r == MD_ST_DIV),
        .acc_hi  (acc_hi_r),
        .acc_lo  (acc_lo_r),
        .operand (operand_r),
        .next_hi (step_hi_s),
        .next_lo (step_lo_s)
    );

    // Launch decode and operand magnitudes for signed ops
    always_comb begin
        is_signed_s = op_is_signed(op);
        div_zero_s  = op_is_div(op) && (src2 == {WIDTH{1'b0}});
        launch_s    = (state_r == MD_ST_IDLE) && start && !cancel;
        if (is_signed_s && src1[WIDTH-1]) begin
            mag1_s = -src1;
        end else begin
            mag1_s = src1;
        end
        if (is_signed_s && src2[WIDTH-1]) begin
            mag2_s = -src2;
        end else begin
            mag2_s = src2;
        end
    end

    // Sign-corrected result from the final iteration, committed on the edge into DONE
    always_comb begin
        if (neg_res_r) begin
            prod_s = -{step_hi_s, step_lo_s};
        end else begin
            prod_s = {step_hi_s, step_lo_s};
        end
        if (state_r == MD_ST_DIV) begin
            res_lo_s = neg_res_r ? -step_lo_s : step_lo_s;
            res_hi_s = neg_rem_r ? -step_hi_s : step_hi_s;
        end else begin
            res_hi_s = prod_s[2*WIDTH-1:WIDTH];
            res_lo_s = prod_s[WIDTH-1:0];
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= MD_ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic; a flush takes priority over the final iteration
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            MD_ST_IDLE: begin
                if (launch_s) begin
                    if (!op_is_div(op)) begin
                        state_nxt_s = MD_ST_MUL;
                    end else if (div_zero_s) begin
                        state_nxt_s = MD_ST_DONE;
                    end else begin
                        state_nxt_s = MD_ST_DIV;
                    end
                end else begin
                    state_nxt_s = MD_ST_IDLE;
                end
            end
            MD_ST_MUL, MD_ST_DIV: begin
                if (cancel) begin
                    state_nxt_s = MD_ST_IDLE;
                end else if (cnt_r == LAST_CNT) begin
                    state_nxt_s = MD_ST_DONE;
                end else begin
                    state_nxt_s = state_r;
                end
            end
            MD_ST_DONE: state_nxt_s = MD_ST_IDLE;
            default:    state_nxt_s = MD_ST_IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        busy      = (state_r == MD_ST_MUL) || (state_r == MD_ST_DIV);
        done      = (state_r == MD_ST_DONE);
        stall_req = busy || (start && (state_r == MD_ST_IDLE));
    end

    // Datapath: operand capture, iteration, HI/LO writes
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r     <= {CNT_W{1'b0}};
            acc_hi_r  <= {WIDTH{1'b0}};
            acc_lo_r  <= {WIDTH{1'b0}};
            operand_r <= {WIDTH{1'b0}};
            neg_res_r <= 1'b0;
            neg_rem_r <= 1'b0;
            hi_r      <= {WIDTH{1'b0}};
            lo_r      <= {WIDTH{1'b0}};
        end else begin
            case (state_r)
                MD_ST_IDLE: begin
                    cnt_r <= {CNT_W{1'b0}};
                    if (wr_hi) hi_r <= wr_data;
                    if (wr_lo) lo_r <= wr_data;
                    if (launch_s) begin
                        neg_res_r <= is_signed_s & (src1[WIDTH-1] ^ src2[WIDTH-1]);
                        neg_rem_r <= is_signed_s & src1[WIDTH-1];
                        acc_hi_r  <= {WIDTH{1'b0}};
                        if (op_is_div(op)) begin
                            acc_lo_r  <= mag1_s;
                            operand_r <= mag2_s;
                        end else begin
                            acc_lo_r  <= mag2_s;
                            operand_r <= mag1_s;
                        end
                        // Divide by zero commits immediately; raw dividend, no sign fix
                        if (div_zero_s) begin
                            hi_r <= src1;
                            lo_r <= {WIDTH{1'b1}};
                        end
                    end
                end
                MD_ST_MUL, MD_ST_DIV: begin
                    if (cancel) begin
                        cnt_r <= {CNT_W{1'b0}};
                    end else begin
                        acc_hi_r <= step_hi_s;
                        acc_lo_r <= step_lo_s;
                        cnt_r    <= cnt_r + CNT_W'(1);
                        if (cnt_r == LAST_CNT) begin
                            hi_r <= res_hi_s;
                            lo_r <= res_lo_s;
                        end
                    end
                end
                MD_ST_DONE: cnt_r <= {CNT_W{1'b0}};
                default:    cnt_r <= {CNT_W{1'b0}};
            endcase
        end
    end

    assign hi = hi_r;
    assign lo = lo_r;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit (WIDTH=32): directed table, randomized ops
// against an arithmetic reference model, and hand-written cancel/reset/write sequences.
module tb_muldiv_unit;
    import muldiv_pkg::*;

    logic        clk = 1'b0;
    logic        rst, start, cancel, wr_hi, wr_lo;
    logic [1:0]  op;
    logic [31:0] src1, src2, wr_data;
    logic        busy, stall_req, done;
    logic [31:0] hi, lo;

    int checks   = 0;
    int failures = 0;

    muldiv_unit #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .src1(src1), .src2(src2),
        .cancel(cancel), .wr_hi(wr_hi), .wr_lo(wr_lo), .wr_data(wr_data),
        .busy(busy), .stall_req(stall_req), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a, b, hi, lo;
        int          lat;
        string       name;
    } vec_t;

    vec_t vecs[12];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // Reference: plain 64-bit arithmetic; SV signed / and % truncate toward zero
    function automatic logic [63:0] ref_model(input logic [1:0] o, input logic [31:0] a,
                                              input logic [31:0] b);
        longint      sa, sb, q, r;
        logic [63:0] ua, ub, res;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        res = 64'd0;
        case (o)
            2'b00: begin q = sa * sb; res = q; end
            2'b01: res = ua * ub;
            2'b10: begin
                if (b == 32'd0) res = {a, 32'hFFFF_FFFF};
                else begin q = sa / sb; r = sa % sb; res = {r[31:0], q[31:0]}; end
            end
            default: begin
                if (b == 32'd0) res = {a, 32'hFFFF_FFFF};
                else res = {32'(ua % ub), 32'(ua / ub)};
            end
        endcase
        return res;
    endfunction

    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] eh, input logic [31:0] el, input int lat,
                          input string nm);
        int cyc;
        op = o; src1 = a; src2 = b; start = 1'b1;
        #1;
        chk({nm, "_stall"}, 64'(stall_req), 64'd1);
        tick();
        start = 1'b0;
        chk({nm, "_busy"}, 64'(busy), (lat > 1) ? 64'd1 : 64'd0);
        cyc = 1;
        while (done !== 1'b1 && cyc < 200) begin
            tick();
            cyc++;
        end
        chk({nm, "_latency"}, 64'(cyc), 64'(lat));
        chk({nm, "_hi"}, 64'(hi), 64'(eh));
        chk({nm, "_lo"}, 64'(lo), 64'(el));
        tick();
        chk({nm, "_done_drop"}, 64'(done), 64'd0);
    endtask

    task automatic wait_done(input string nm);
        int cyc;
        cyc = 0;
        while (done !== 1'b1 && cyc < 200) begin
            tick();
            cyc++;
        end
        chk({nm, "_done_seen"}, 64'(done), 64'd1);
    endtask

    initial begin
        logic [63:0] exp;
        logic [1:0]  ro;
        logic [31:0] ra, rb;
        logic        seen;

        rst = 1'b1; start = 1'b0; cancel = 1'b0; wr_hi = 1'b0; wr_lo = 1'b0;
        op = 2'b00; src1 = 32'd0; src2 = 32'd0; wr_data = 32'd0;
        repeat (2) tick();
        rst = 1'b0;
        chk("reset_hi", 64'(hi), 64'd0);
        chk("reset_lo", 64'(lo), 64'd0);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_done", 64'(done), 64'd0);
        chk("reset_stall", 64'(stall_req), 64'd0);

        vecs[0]  = '{MD_MULT,  32'hFFFF_FFFD, 32'd7,        32'hFFFF_FFFF, 32'hFFFF_FFEB, 33, "mult_m3x7"};
        vecs[1]  = '{MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 33, "multu_max"};
        vecs[2]  = '{MD_DIV,   32'd7,        32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 33, "div_7_m2"};
        vecs[3]  = '{MD_DIVU,  32'hFFFF_FFFF, 32'h10,       32'h0000_000F, 32'h0FFF_FFFF, 33, "divu_max_16"};
        vecs[4]  = '{MD_DIV,   32'd5,        32'd0,        32'h0000_0005, 32'hFFFF_FFFF, 1,  "div_5_0"};
        vecs[5]  = '{MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 33, "div_minneg_m1"};
        vecs[6]  = '{MD_DIV,   32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD, 33, "div_m7_2"};
        vecs[7]  = '{MD_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 33, "mult_minneg_sq"};
        vecs[8]  = '{MD_DIV,   32'hFFFF_FFF7, 32'd0,        32'hFFFF_FFF7, 32'hFFFF_FFFF, 1,  "div_m9_0_raw"};
        vecs[9]  = '{MD_DIVU,  32'h8000_0003, 32'd0,        32'h8000_0003, 32'hFFFF_FFFF, 1,  "divu_by_0"};
        vecs[10] = '{MD_MULTU, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000, 33, "multu_carry"};
        vecs[11] = '{MD_DIVU,  32'd3,        32'd7,        32'h0000_0003, 32'h0000_0000, 33, "divu_small"};

        for (int i = 0; i < 12; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo, vecs[i].lat, vecs[i].name);
        end

        // Randomized ops with operand corner values mixed in
        for (int i = 0; i < 40; i++) begin
            ro = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 5))
                0: ra = 32'h8000_0000;
                1: ra = 32'hFFFF_FFFF;
                default: ra = $urandom;
            endcase
            case ($urandom_range(0, 6))
                0: rb = 32'd0;
                1: rb = 32'hFFFF_FFFF;
                2: rb = 32'd1;
                default: rb = $urandom;
            endcase
            exp = ref_model(ro, ra, rb);
            run_op(ro, ra, rb, exp[63:32], exp[31:0],
                   (ro[1] && rb == 32'd0) ? 1 : 33, "rand");
        end

        // MTHI/MTLO in IDLE set known prior values
        wr_hi = 1'b1; wr_lo = 1'b1; wr_data = 32'hAAAA_5555;
        tick();
        wr_hi = 1'b0; wr_lo = 1'b0;
        chk("mthi_idle", 64'(hi), 64'hAAAA_5555);
        chk("mtlo_idle", 64'(lo), 64'hAAAA_5555);

        // Cancel at iteration 10: back to IDLE, no done, HI/LO untouched
        op = MD_MULTU; src1 = 32'd2; src2 = 32'd3; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (10) tick();
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        chk("cancel_busy", 64'(busy), 64'd0);
        chk("cancel_done", 64'(done), 64'd0);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            seen = seen | done;
        end
        chk("cancel_no_done", 64'(seen), 64'd0);
        chk("cancel_hi", 64'(hi), 64'hAAAA_5555);
        chk("cancel_lo", 64'(lo), 64'hAAAA_5555);

        // Reset at iteration 10 clears HI/LO
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (10) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_mid_hi", 64'(hi), 64'd0);
        chk("rst_mid_lo", 64'(lo), 64'd0);
        chk("rst_mid_busy", 64'(busy), 64'd0);

        // start together with cancel: nothing launches
        op = MD_MULT; src1 = 32'd9; src2 = 32'd9; start = 1'b1; cancel = 1'b1;
        tick();
        start = 1'b0; cancel = 1'b0;
        chk("start_cancel_busy", 64'(busy), 64'd0);
        chk("start_cancel_done", 64'(done), 64'd0);

        // MTHI in IDLE, then ignored in MUL; start while busy ignored
        wr_hi = 1'b1; wr_data = 32'h1234_5678;
        tick();
        wr_hi = 1'b0;
        chk("mthi_write", 64'(hi), 64'h1234_5678);
        op = MD_MULTU; src1 = 32'd2; src2 = 32'd3; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        wr_hi = 1'b1; wr_data = 32'hDEAD_BEEF;
        tick();
        wr_hi = 1'b0;
        chk("mthi_in_mul", 64'(hi), 64'h1234_5678);
        op = MD_MULT; src1 = 32'd9; src2 = 32'd9; start = 1'b1;
        tick();
        start = 1'b0;
        wait_done("busy_start");
        chk("busy_start_hi", 64'(hi), 64'd0);
        chk("busy_start_lo", 64'(lo), 64'd6);
        tick();
        tick();
        chk("no_queued_op", 64'(busy), 64'd0);

        // MTLO in the same cycle as start: write lands, op still runs
        op = MD_MULTU; src1 = 32'd4; src2 = 32'd5; start = 1'b1;
        wr_lo = 1'b1; wr_data = 32'hCAFE_F00D;
        tick();
        start = 1'b0; wr_lo = 1'b0;
        chk("mtlo_with_start", 64'(lo), 64'hCAFE_F00D);
        chk("mtlo_with_start_busy", 64'(busy), 64'd1);
        wait_done("mtlo_start");
        chk("mtlo_start_lo", 64'(lo), 64'd20);

        // cancel and MTLO during DONE are ignored
        tick();
        op = MD_MULTU; src1 = 32'd7; src2 = 32'd6; start = 1'b1;
        tick();
        start = 1'b0;
        wait_done("done_cancel");
        cancel = 1'b1; wr_lo = 1'b1; wr_data = 32'h0BAD_0BAD;
        tick();
        cancel = 1'b0; wr_lo = 1'b0;
        chk("done_cancel_lo", 64'(lo), 64'd42);
        chk("done_cancel_hi", 64'(hi), 64'd0);
        chk("done_to_idle", 64'(done), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
